ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of tracked keys (1..16).
REQ-002 SHALL have parameter KEY_CODES, default {9'h172, 9'h175, 9'h01D, 9'h029}, packed NUM_KEYS x 9 bits. Each entry is {extended, make code}. Index 0 is the least significant entry (space, 9'h029).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for KBclk/KBin (2..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000, the maximum clk cycles allowed between PS/2 falling edges inside a frame.
REQ-005 SHALL have port clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port KBclk, input, 1, PS/2 clock, asynchronous to clk.
REQ-008 SHALL have port KBin, input, 1, PS/2 data, asynchronous to clk.
REQ-009 SHALL have port rx_data, output, 8, last received byte.
REQ-010 SHALL have port rx_valid, output, 1, one-cycle pulse marking a good frame.
REQ-011 SHALL have port rx_err, output, 1, one-cycle pulse on a parity, stop-bit or timeout error.
REQ-012 SHALL have port key_down, output, NUM_KEYS, level: key i is currently held.
REQ-013 SHALL have port key_press, output, NUM_KEYS, one-cycle pulse on key i transitioning up->down.
REQ-014 SHALL have port key_release, output, NUM_KEYS, one-cycle pulse on key i transitioning down->up.

Function
REQ-015 SHALL pass KBclk and KBin through SYNC_STAGES flops each, then detect a falling edge of the synchronised KBclk as a one-cycle strobe.
REQ-016 SHALL run frame FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on a strobe and sampling synchronised KBin at that strobe.
REQ-017 IDLE: a strobe with data 0 (start bit) SHALL go to DATA with bit count 0. A strobe with data 1 SHALL be ignored.
REQ-018 DATA: SHALL shift 8 bits LSB first, going to PARITY after the 8th bit.
REQ-019 PARITY: SHALL capture the parity bit and go to STOP.
REQ-020 STOP: if stop=1 and the 9 data+parity bits have odd parity, SHALL load rx_data and pulse rx_valid in the cycle after the strobe. Otherwise SHALL pulse rx_err and leave rx_data unchanged. Both cases return to IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYCLES clk cycles with no strobe SHALL force IDLE and pulse rx_err. The counter SHALL clear on every strobe and while in IDLE.
REQ-022 Decoder, on rx_valid, byte 8'hE0: SHALL set ext flag and do nothing else.
REQ-023 Decoder, on rx_valid, byte 8'hF0: SHALL set brk flag and do nothing else.
REQ-024 Decoder, on rx_valid, any other byte: SHALL compare {ext, byte} against every KEY_CODES entry, then clear ext and brk.
REQ-025 On a match with brk=0: SHALL set key_down[i]. key_press[i] SHALL pulse only if key_down[i] was 0, so typematic repeats give no pulse.
REQ-026 On a match with brk=1: SHALL clear key_down[i]. key_release[i] SHALL pulse only if key_down[i] was 1.
REQ-027 key_down/key_press/key_release SHALL update in the cycle after rx_valid. Total latency from the stop-bit strobe is 2 clk cycles.
REQ-028 An unmatched byte SHALL change no key output.
REQ-029 Duplicate KEY_CODES entries SHALL all update together.
REQ-030 rx_err SHALL clear ext and brk. key_down SHALL be unaffected.
REQ-031 A 9'h029 make with ext=1 (E0 29) SHALL NOT match the plain 9'h029 entry.

Reset
REQ-032 With rst=0 at a clk edge, SHALL clear all of the following:
- synchroniser flops to 1 (PS/2 idle high);
- FSM to IDLE, bit count 0, timeout counter 0;
- ext and brk flags;
- rx_data=8'h00, rx_valid=0, rx_err=0;
- key_down, key_press and key_release all 0.
REQ-033 Reset mid-frame SHALL discard the partial frame. The first strobe after release SHALL be treated as a potential start bit.

Structure
REQ-034 Shared package SHALL hold the frame FSM state enum, PS2_BREAK=8'hF0, PS2_EXT=8'hE0, and the key-entry width 9.
REQ-035 SHALL instantiate one sub-module, ps2_frame_rx, covering REQ-015..REQ-021. The key decoder SHALL remain in ps2_key_decoder.

Verification
REQ-036 Frame 29 with good parity, then F0, 29 -> key_down[0] rises with one key_press[0] pulse 2 cycles after the stop strobe, then falls with one key_release[0] pulse.
REQ-037 Three consecutive 29 makes -> key_down[0]=1 and exactly one key_press[0] pulse.
REQ-038 E0 75, then E0 F0 75 -> key_down[2] sets then clears. key_down[0] stays 0 throughout.
REQ-039 Frame 29 with wrong parity -> rx_err pulse, no rx_valid, key outputs unchanged. The next good frame decodes normally.
REQ-040 Start bit plus 4 data bits, then KBclk held high > TIMEOUT_CYCLES -> one rx_err pulse and FSM in IDLE. A following good 29 sets key_down[0].
REQ-041 rst=0 asserted mid-frame with key_down[0]=1 -> all outputs 0 on the next edge. After release, a full 29 frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 receiver and key decoder.
// Frame FSM encoding, the PS/2 prefix bytes and the key-table entry width.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0]  PS2_BREAK = 8'hF0;
    localparam logic [7:0]  PS2_EXT   = 8'hE0;
    localparam int unsigned KEY_W     = 9;

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronises KBclk/KBin, strobes on KBclk falling edges
// and assembles start/8 data/odd parity/stop frames with an inter-edge timeout.
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KBclk,
    input  logic       KBin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   strobe;
    logic                   bit_in;

    frame_state_t state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift_reg, shift_n;
    logic             par_bit, par_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic [7:0]       data_n;
    logic             valid_n, err_n;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], KBclk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], KBin};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign strobe = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            tmo_cnt   <= tmo_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            rx_err    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        par_n     = par_bit;
        tmo_n     = tmo_cnt;
        data_n    = rx_data;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (strobe) begin
            tmo_n = '0;
            case (state)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end
                end
                ST_DATA: begin
                    shift_n   = {bit_in, shift_reg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = bit_in;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    if (bit_in && (^{shift_reg, par_bit})) begin
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_n = ST_IDLE;
                err_n   = 1'b1;
                tmo_n   = '0;
            end else begin
                tmo_n = tmo_cnt + TMO_W'(1);
            end
        end else begin
            tmo_n = '0;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: tracks held state of a table of {extended, make} codes,
// handling E0 (extended) and F0 (break) prefixes from the frame receiver.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*KEY_W-1:0]      KEY_CODES      = {9'h172, 9'h175, 9'h01D, 9'h029},
    parameter int unsigned                    SYNC_STAGES    = 2,
    parameter int unsigned                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                KBclk,
    input  logic                KBin,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                rx_err,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    logic ext;
    logic brk;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk      (clk),
        .rst      (rst),
        .KBclk    (KBclk),
        .KBin     (KBin),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    // Prefix flags only clear on a terminating byte or a receive error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_data == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rx_data == PS2_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                        if (KEY_CODES[i*KEY_W +: KEY_W] == {ext, rx_data}) begin
                            if (brk) begin
                                key_down[i]    <= 1'b0;
                                key_release[i] <= key_down[i];
                            end else begin
                                key_down[i]  <= 1'b1;
                                key_press[i] <= ~key_down[i];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of PS/2 frames with expected
// key state, a receive-event scoreboard, and hand sequences for timing corners.
module tb_ps2_key_decoder;

    localparam int HALF = 20;
    localparam int TMO  = 200;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       KBclk = 1'b1;
    logic       KBin  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [3:0] key_down;
    logic [3:0] key_press;
    logic [3:0] key_release;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .NUM_KEYS       (4),
        .KEY_CODES      ({9'h172, 9'h175, 9'h01D, 9'h029}),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .KBclk       (KBclk),
        .KBin        (KBin),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    exp_q[$];
    rx_exp_t    mon_e;
    logic [7:0] last_good  = 8'h00;
    logic       prev_valid = 1'b0;
    int         press_cnt[4];
    int         rel_cnt[4];

    // Scoreboard: every receive event must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid || rx_err) begin
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", {30'd0, rx_valid, rx_err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_kind", {30'd0, rx_valid, rx_err}, mon_e.is_err ? 32'd1 : 32'd2);
                    if (mon_e.is_err) begin
                        chk("rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
                    end else begin
                        chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                        last_good = mon_e.data;
                    end
                end
            end
            if ((key_press | key_release) != 4'd0)
                chk("pulse_timing", {31'd0, prev_valid}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                press_cnt[i] += int'(key_press[i]);
                rel_cnt[i]   += int'(key_release[i]);
            end
        end
        prev_valid = rx_valid;
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            KBin = bits[i];
            repeat (HALF) @(posedge clk);
            KBclk = 1'b0;
            repeat (HALF) @(posedge clk);
            KBclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic    par;
        logic    stop;
        rx_exp_t e;
        par      = ~(^d) ^ bad_par;
        stop     = ~bad_stop;
        e.is_err = bad_par | bad_stop;
        e.data   = d;
        exp_q.push_back(e);
        send_bits({stop, par, d, 1'b0}, 11);
        repeat (HALF) @(posedge clk);
    endtask

    function automatic logic [31:0] pack_cnt(input logic [3:0] dummy, input bit rel);
        logic [31:0] r;
        int          c;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            c = rel ? rel_cnt[i] : press_cnt[i];
            r[i*2 +: 2] = (c > 3) ? 2'd3 : 2'(c);
        end
        return r | {28'd0, dummy & 4'd0};
    endfunction

    function automatic logic [31:0] exp_cnt(input logic [3:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*2 +: 2] = {1'b0, v[i]};
        return r;
    endfunction

    task automatic apply(input string name, input logic [7:0] d, input bit bp, input bit bs,
                         input logic [3:0] ed, input logic [3:0] ep, input logic [3:0] er);
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        send_frame(d, bp, bs);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk({name, ".down"},    {28'd0, key_down},            {28'd0, ed});
        chk({name, ".press"},   pack_cnt(4'd0, 1'b0),         exp_cnt(ep));
        chk({name, ".release"}, pack_cnt(4'd0, 1'b1),         exp_cnt(er));
    endtask

    typedef struct {
        logic [7:0] d;
        bit         bp;
        bit         bs;
        logic [3:0] ed;
        logic [3:0] ep;
        logic [3:0] er;
    } vec_t;

    vec_t vecs[23];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        // Key order: 0=29 space, 1=1D, 2=E0 75, 3=E0 72
        vecs[0]  = '{8'h29, 0, 0, 4'b0001, 4'b0001, 4'b0000};
        vecs[1]  = '{8'h29, 0, 0, 4'b0001, 4'b0000, 4'b0000};
        vecs[2]  = '{8'h29, 0, 0, 4'b0001, 4'b0000, 4'b0000};
        vecs[3]  = '{8'hF0, 0, 0, 4'b0001, 4'b0000, 4'b0000};
        vecs[4]  = '{8'h29, 0, 0, 4'b0000, 4'b0000, 4'b0001};
        vecs[5]  = '{8'hE0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{8'h75, 0, 0, 4'b0100, 4'b0100, 4'b0000};
        vecs[7]  = '{8'hE0, 0, 0, 4'b0100, 4'b0000, 4'b0000};
        vecs[8]  = '{8'hF0, 0, 0, 4'b0100, 4'b0000, 4'b0000};
        vecs[9]  = '{8'h75, 0, 0, 4'b0000, 4'b0000, 4'b0100};
        vecs[10] = '{8'hE0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        vecs[11] = '{8'h29, 0, 0, 4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{8'h29, 0, 0, 4'b0001, 4'b0001, 4'b0000};
        vecs[13] = '{8'h29, 1, 0, 4'b0001, 4'b0000, 4'b0000};
        vecs[14] = '{8'h1D, 0, 0, 4'b0011, 4'b0010, 4'b0000};
        vecs[15] = '{8'hF0, 0, 0, 4'b0011, 4'b0000, 4'b0000};
        vecs[16] = '{8'h1D, 0, 1, 4'b0011, 4'b0000, 4'b0000};
        vecs[17] = '{8'h1D, 0, 0, 4'b0011, 4'b0000, 4'b0000};
        vecs[18] = '{8'hF0, 0, 0, 4'b0011, 4'b0000, 4'b0000};
        vecs[19] = '{8'h1D, 0, 0, 4'b0001, 4'b0000, 4'b0010};
        vecs[20] = '{8'hE0, 0, 0, 4'b0001, 4'b0000, 4'b0000};
        vecs[21] = '{8'h72, 0, 0, 4'b1001, 4'b1000, 4'b0000};
        vecs[22] = '{8'h12, 0, 0, 4'b1001, 4'b0000, 4'b0000};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.keys", {20'd0, key_down, key_press, key_release}, 32'd0);
        chk("reset.rx",   {22'd0, rx_data, rx_valid, rx_err},        32'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 23; v++)
            apply($sformatf("vec%0d", v), vecs[v].d, vecs[v].bp, vecs[v].bs,
                  vecs[v].ed, vecs[v].ep, vecs[v].er);

        // Break prefix, then a truncated frame times out and must drop the prefix.
        apply("tmo_brk", 8'hF0, 0, 0, 4'b1001, 4'b0000, 4'b0000);
        exp_q.push_back('{1'b1, 8'h00});
        send_bits({2'b11, 8'h29, 1'b0}, 5);
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        chk("tmo.queue", exp_q.size(), 32'd0);
        apply("tmo_after", 8'h29, 0, 0, 4'b1001, 4'b0000, 4'b0000);
        apply("rel_brk",   8'hF0, 0, 0, 4'b1001, 4'b0000, 4'b0000);
        apply("rel_29",    8'h29, 0, 0, 4'b1000, 4'b0000, 4'b0001);

        // Key outputs lag rx_valid by exactly one cycle.
        fork
            apply("lat_make", 8'h29, 0, 0, 4'b1001, 4'b0001, 4'b0000);
            begin
                n = 0;
                while (!rx_valid && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk("lat.valid_seen", {31'd0, rx_valid}, 32'd1);
                chk("lat.no_early",   {31'd0, key_press[0]}, 32'd0);
                @(negedge clk);
                chk("lat.press", {30'd0, key_press[0], key_down[0]}, 32'd3);
            end
        join

        // Reset in the middle of a frame with keys held.
        send_bits({2'b11, 8'h29, 1'b0}, 3);
        KBin  = 1'b0;
        KBclk = 1'b0;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.keys", {20'd0, key_down, key_press, key_release}, 32'd0);
        chk("midrst.rx",   {22'd0, rx_data, rx_valid, rx_err},        32'd0);
        last_good = 8'h00;
        KBclk = 1'b1;
        KBin  = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        apply("post_rst", 8'h29, 0, 0, 4'b0001, 4'b0001, 4'b0000);

        repeat (20) @(posedge clk);
        chk("final.queue", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
